// File: rtl/sample_capture_fifo.sv
// sample_capture_fifo: ADC capture with test ramp, windowed DC-offset compensation and FWFT FIFO
// Ports: fx3_clock/reset (async, active-high); collectData/sampleValid/adcData qualify samples;
// testMode selects the ramp; dcOffsetComp enables compensation; readData pops the head;
// dataOut is the FWFT head; dataAvailable = fifoLevel >= AVAILABLE_THRESHOLD; bufferError is sticky.
module sample_capture_fifo #(
  parameter int SAMPLE_WIDTH        = 10,
  parameter int OUTPUT_WIDTH        = 16,
  parameter int FIFO_DEPTH          = 16384,
  parameter int AVAILABLE_THRESHOLD = 8192,
  parameter int DC_AVG_LOG2         = 16,
  parameter int TEST_WRAP           = 1021
) (
  input  logic                          fx3_clock,
  input  logic                          reset,
  input  logic                          collectData,
  input  logic                          sampleValid,
  input  logic [SAMPLE_WIDTH-1:0]       adcData,
  input  logic                          testMode,
  input  logic                          dcOffsetComp,
  input  logic                          readData,
  output logic [OUTPUT_WIDTH-1:0]       dataOut,
  output logic                          dataAvailable,
  output logic                          bufferError,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);
  localparam int SW = SAMPLE_WIDTH;
  localparam int OW = OUTPUT_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int AL = DC_AVG_LOG2 + SAMPLE_WIDTH;
  localparam logic [SW-1:0] RAMP_MAX = SW'(TEST_WRAP - 1);
  localparam logic [SW:0] HALF = {2'b01, {(SW-1){1'b0}}};
  localparam logic [DC_AVG_LOG2:0] WFULL = {1'b1, {DC_AVG_LOG2{1'b0}}};
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] THRESH = (AW+1)'(AVAILABLE_THRESHOLD);
  logic collect_q;
  logic [SW-1:0] ramp_q, ramp_d, ramp_cur, sample;
  logic [SW-1:0] s1_q, s1_d, comp;
  logic s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [OW-1:0] s2_q, s2_d;
  logic [AL-1:0] acc_q, acc_d, acc_cur;
  logic [DC_AVG_LOG2:0] wcnt_q, wcnt_d, wcnt_cur;
  logic [SW:0] off_q, off_d;
  logic [SW+1:0] diff;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d, rd_nx;
  logic [AW:0] lvl_q, lvl_d;
  logic [OW-1:0] dout_q, dout_d;
  logic err_q, err_d;
  logic start, accept, wend, wr_req, do_wr, do_rd, empty, full;
  logic [OW-1:0] mem [FIFO_DEPTH];
  always_comb begin
    start    = collectData & ~collect_q;
    accept   = collectData & sampleValid;
    ramp_cur = start ? '0 : ramp_q;
    acc_cur  = start ? '0 : acc_q;
    wcnt_cur = start ? '0 : wcnt_q;
    sample   = testMode ? ramp_cur : adcData;
    ramp_d   = !accept ? ramp_cur : (ramp_cur == RAMP_MAX) ? '0 : ramp_cur + 1'b1;
    // A window closes when the next sample arrives after 2^DC_AVG_LOG2 have been summed;
    // that sample then opens the following window.
    wend     = accept & (wcnt_cur == WFULL);
    acc_d    = !accept ? acc_cur : wend ? AL'(sample) : acc_cur + AL'(sample);
    wcnt_d   = !accept ? wcnt_cur : wend ? (DC_AVG_LOG2+1)'(1) : wcnt_cur + 1'b1;
    off_d    = wend ? {1'b0, acc_cur[AL-1:DC_AVG_LOG2]} - HALF : off_q;
    s1_d     = accept ? sample : s1_q;
    s1_v_d   = accept;
    diff     = {2'b00, s1_q} - {off_q[SW], off_q};
    comp     = !dcOffsetComp ? s1_q : diff[SW+1] ? '0 : diff[SW] ? '1 : diff[SW-1:0];
    s2_d     = OW'(comp) << (OW - SW);
    s2_v_d   = s1_v_q & ~start;
    empty    = lvl_q == '0;
    full     = lvl_q == FULL_LVL;
    wr_req   = s2_v_q & ~start;
    do_rd    = readData & ~empty & ~start;
    do_wr    = wr_req & (~full | do_rd);
    err_d    = start ? 1'b0 : err_q | (wr_req & full & ~do_rd) | (readData & empty);
    wr_d     = start ? '0 : wr_q + AW'(do_wr);
    rd_d     = start ? '0 : rd_q + AW'(do_rd);
    lvl_d    = start ? '0 : lvl_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    rd_nx    = rd_q + 1'b1;
    // Head register reloads every cycle so a word written into an empty FIFO shows one edge later.
    dout_d   = (start | empty) ? dout_q : do_rd ? ((lvl_q > (AW+1)'(1)) ? mem[rd_nx] : dout_q) : mem[rd_q];
  end
  always_ff @(posedge fx3_clock or posedge reset)
    if (reset) begin
      collect_q <= 1'b0;
      ramp_q    <= '0;
      s1_q      <= '0;
      s1_v_q    <= 1'b0;
      s2_q      <= '0;
      s2_v_q    <= 1'b0;
      acc_q     <= '0;
      wcnt_q    <= '0;
      off_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      lvl_q     <= '0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      collect_q <= collectData;
      ramp_q    <= ramp_d;
      s1_q      <= s1_d;
      s1_v_q    <= s1_v_d;
      s2_q      <= s2_d;
      s2_v_q    <= s2_v_d;
      acc_q     <= acc_d;
      wcnt_q    <= wcnt_d;
      off_q     <= off_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      lvl_q     <= lvl_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
    end
  always_ff @(posedge fx3_clock)
    if (do_wr) mem[wr_q] <= s2_q;
  assign dataOut       = dout_q;
  assign fifoLevel     = lvl_q;
  assign bufferError   = err_q;
  assign dataAvailable = lvl_q >= THRESH;
endmodule
